// File: rtl/alu_sequencer.sv
// alu_sequencer: loads two 5x5 byte matrices from memory, runs an
// external ALU on them and writes the 5x5 result back to memory.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, op, scalar   one-cycle command, opcode and scalar factor
//   busy, done          not-idle flag, one-cycle completion pulse
//   err, ovf            invalid-opcode flag, captured ALU overflow
//   mem_*               byte memory port (1-cycle read latency)
//   alu_A/B_flat, alu_f, alu_opcode   ALU operands
//   alu_C_flat, alu_ovf               ALU result
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [7:0]   scalar,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         ovf,
  output logic [6:0]   mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [7:0]   mem_wdata,
  input  logic [7:0]   mem_rdata,
  output logic [199:0] alu_A_flat,
  output logic [199:0] alu_B_flat,
  output logic [7:0]   alu_f,
  output logic [2:0]   alu_opcode,
  input  logic [199:0] alu_C_flat,
  input  logic         alu_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_CAPTURE,
    S_STORE,
    S_DONE
  } state_e;

  localparam logic [4:0] SETTLE_LAST =
    5'(SETTLE_CYCLES - 1);
  localparam logic [4:0] LOAD_LAST  = 5'd25;
  localparam logic [4:0] ELEM_LAST  = 5'd24;
  localparam logic [6:0] B_BASE     = 7'd32;
  localparam logic [6:0] C_BASE     = 7'd64;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] op_q, op_d;
  logic [7:0] scalar_q, scalar_d;
  logic err_q, err_d;
  logic ovf_q, ovf_d;

  logic [24:0][7:0] a_q, a_d;
  logic [24:0][7:0] b_q, b_d;
  logic [24:0][7:0] res_q, res_d;

  logic       op_valid;
  logic       op_binary;
  logic [4:0] elem;
  logic       rd_slot;

  assign op_valid  = (op != 3'd0) && (op != 3'd7);

  always_comb begin
    op_binary = 1'b0;
    unique case (1'b1)
      (op_q == 3'd1): op_binary = 1'b1;
      (op_q == 3'd2): op_binary = 1'b1;
      (op_q == 3'd3): op_binary = 1'b1;
      default:        op_binary = 1'b0;
    endcase
  end

  // Load data returns one cycle after its read, so the element being
  // written trails the read counter by one.
  assign elem    = cnt_q - 5'd1;
  assign rd_slot = (cnt_q <= ELEM_LAST);

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign ovf        = ovf_q;
  assign alu_A_flat = a_q;
  assign alu_B_flat = b_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    scalar_d   = scalar_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    mem_addr   = 7'd0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_wdata  = 8'd0;
    alu_f      = 8'd0;
    alu_opcode = 3'd0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = !op_valid;
          ovf_d = 1'b0;
          cnt_d = 5'd0;
          if (op_valid) begin
            op_d     = op;
            scalar_d = scalar;
            state_d  = S_LOAD_A;
          end else begin
            state_d  = S_DONE;
          end
        end
      end

      S_LOAD_A: begin
        if (rd_slot) begin
          mem_rd   = 1'b1;
          mem_addr = {2'b00, cnt_q};
        end
        if (cnt_q != 5'd0) begin
          a_d[elem] = mem_rdata;
        end
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = 5'd0;
          state_d = op_binary ? S_LOAD_B : S_EXEC;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_LOAD_B: begin
        if (rd_slot) begin
          mem_rd   = 1'b1;
          mem_addr = B_BASE + {2'b00, cnt_q};
        end
        if (cnt_q != 5'd0) begin
          b_d[elem] = mem_rdata;
        end
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = 5'd0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_EXEC: begin
        alu_opcode = op_q;
        alu_f      = scalar_q;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 5'd0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      // Opcode stays applied so the ALU output is still
      // stable while it is registered.
      S_CAPTURE: begin
        alu_opcode = op_q;
        alu_f      = scalar_q;
        res_d      = alu_C_flat;
        ovf_d      = alu_ovf;
        cnt_d      = 5'd0;
        state_d    = S_STORE;
      end

      S_STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = C_BASE + {2'b00, cnt_q};
        mem_wdata = res_q[cnt_q];
        if (cnt_q == ELEM_LAST) begin
          cnt_d   = 5'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      scalar_q <= 8'd0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      scalar_q <= scalar_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Parameters
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning the cycles the ALU opcode is held before the result is captured (legal range 1..15).

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle command request, accepted only in IDLE.
REQ-005 The block SHALL have port op, input, 3, the operation code, sampled with start.
REQ-006 The block SHALL have port scalar, input, 8, the scalar factor, sampled with start.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port err, output, 1, the invalid-opcode flag, valid with done and held until the next accepted start.
REQ-010 The block SHALL have port ovf, output, 1, the captured ALU overflow, held until the next accepted start.
REQ-011 The block SHALL have ports mem_addr (output, 7), mem_rd (output, 1), mem_wr (output, 1), mem_wdata (output, 8) and mem_rdata (input, 8), forming the byte memory port.
REQ-012 The block SHALL have ports alu_A_flat (output, 200), alu_B_flat (output, 200), alu_f (output, 8) and alu_opcode (output, 3), which drive the ALU.
REQ-013 The block SHALL have ports alu_C_flat (input, 200) and alu_ovf (input, 1), the ALU result.

Function
REQ-014 Matrix layout SHALL be 5x5 of 8-bit elements; element i (0..24, row-major) occupies bits [8i+7:8i].
REQ-015 Memory map SHALL be fixed:
- A at addresses 0..24
- B at addresses 32..56
- C (result) at addresses 64..88
REQ-016 Memory read latency SHALL be 1: mem_rdata is valid in the cycle after the cycle in which mem_rd and mem_addr are driven.
REQ-017 A memory write SHALL take effect in the cycle mem_wr is high.
REQ-018 State machine SHALL be IDLE, LOAD_A, LOAD_B, EXEC, CAPTURE, STORE, DONE.
REQ-019 In IDLE, start with op in {001..110} SHALL latch op and scalar, clear err and ovf, and enter LOAD_A on the next cycle.
REQ-020 In IDLE, start with op equal to 000 or 111 SHALL cause no memory access and SHALL go to DONE with err=1; the done pulse occurs 1 cycle after start.
REQ-021 LOAD_A SHALL last 26 cycles:
- reads issued at addresses 0..24 in cycles 0..24
- the returned byte written into element k of alu_A_flat in cycles 1..25
REQ-022 After LOAD_A, ops 001, 010 and 011 SHALL enter LOAD_B; ops 100, 101 and 110 SHALL go directly to EXEC.
REQ-023 LOAD_B SHALL behave like LOAD_A but on addresses 32..56, filling alu_B_flat.
REQ-024 alu_opcode SHALL be 000 in every state except EXEC and CAPTURE, so the ALU sees an opcode change for every operation.
REQ-025 EXEC SHALL drive alu_opcode = latched op and alu_f = latched scalar for SETTLE_CYCLES cycles.
REQ-026 CAPTURE SHALL last 1 cycle and register alu_C_flat into an internal result register and alu_ovf into ovf.
REQ-027 STORE SHALL last 25 cycles, writing result element k to address 64+k in cycle k with mem_wr=1.
REQ-028 DONE SHALL last 1 cycle with done=1 and SHALL return to IDLE.
REQ-029 Total latency, from the start cycle to the done cycle, SHALL be:
- binary ops: 79+SETTLE_CYCLES (81 at the default)
- unary ops: 53+SETTLE_CYCLES (55 at the default)
REQ-030 mem_rd and mem_wr SHALL never be high in the same cycle; when both are low, mem_addr is 0.
REQ-031 start SHALL be ignored while busy, with no effect on state, outputs or latched op.
REQ-032 alu_A_flat and alu_B_flat SHALL hold their last values between operations; B is not reloaded for unary ops.

Reset
REQ-033 When rst is high at a clock edge, the block SHALL:
- enter IDLE
- set busy, done, err, ovf, mem_rd and mem_wr to 0
- set mem_addr, mem_wdata and alu_opcode to 0
- clear alu_A_flat, alu_B_flat, alu_f and the result register to 0
REQ-034 Reset mid-operation, including mid-STORE, SHALL stop all memory writes from the next edge onward and SHALL not pulse done.
REQ-035 rst SHALL have priority over start in the same cycle.

Verification
REQ-036 Sum: A[k]=k, B[k]=1, op=001 -> done at cycle 81; mem[64+k]=k+1; ovf=0; err=0.
REQ-037 Transpose: A[k]=k, op=101 -> no reads at 32..56; done at cycle 55; mem[64+5r+c]=5c+r.
REQ-038 Scalar overflow: A[0]=100 (others 0), scalar=3, op=110, ALU model asserting ovf -> ovf=1 at done and held in IDLE until the next start.
REQ-039 Invalid opcode: op=111 -> done and err=1 one cycle after start; mem_rd=mem_wr=0 throughout.
REQ-040 start pulsed again during LOAD_B -> ignored; exactly one done, with the original op's results.
REQ-041 rst asserted at STORE element 10 -> no mem_wr from the next cycle; all outputs at their reset values; a new start completes normally.
